// File: rtl/polar_pkg.sv
// Shared definitions for the polar decoder controllers: state codes,
// default state-bus width and err_status bit positions.
package polar_pkg;

    localparam int POLAR_STATE_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INIT   = 3'd1,
        ST_INPUT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_ERROR  = 3'd5
    } state_e;

    localparam int ERR_BITS       = 3;
    localparam int ERR_INPUT_LEN  = 0;
    localparam int ERR_TIMEOUT    = 1;
    localparam int ERR_START_BUSY = 2;

endpackage

// File: rtl/polar_decode_sequencer_seq_timer.sv
// Shared cycle timer: restarts from zero whenever the sequencer changes state.
module seq_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/polar_decode_sequencer.sv
// Top-level frame sequencer for the polar decoder: walks each frame through
// INIT, INPUT, DECODE and OUTPUT and reports errors and completed frames.
module polar_decode_sequencer
    import polar_pkg::*;
#(
    parameter int          STATE_WIDTH     = POLAR_STATE_WIDTH,
    parameter int unsigned INIT_WAIT       = 20,
    parameter int unsigned DECODE_TIMEOUT  = 16'd65535,
    parameter int          TIMER_WIDTH     = 16,
    parameter int          FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       in_beat_last,
    input  logic                       in_error,
    input  logic                       core_done,
    input  logic                       out_done,
    input  logic                       clear_error,
    output logic [STATE_WIDTH-1:0]     state,
    output logic                       core_start,
    output logic                       busy,
    output logic                       frame_done,
    output logic [ERR_BITS-1:0]        err_status,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [TIMER_WIDTH-1:0] INIT_LAST   = TIMER_WIDTH'(INIT_WAIT - 1);
    localparam logic [TIMER_WIDTH-1:0] DECODE_LAST = TIMER_WIDTH'(DECODE_TIMEOUT - 1);

    state_e                cur_state;
    state_e                next_state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [ERR_BITS-1:0]   err_next;
    logic                  core_start_next;
    logic                  frame_done_next;

    seq_timer #(
        .WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (next_state != cur_state),
        .count  (timer)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state   <= ST_IDLE;
            core_start  <= 1'b0;
            frame_done  <= 1'b0;
            err_status  <= '0;
            frame_count <= '0;
        end else begin
            cur_state   <= next_state;
            core_start  <= core_start_next;
            frame_done  <= frame_done_next;
            err_status  <= err_next;
            if (frame_done_next) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    // core_done is checked before the timeout so a finish on the last allowed cycle still succeeds.
    always_comb begin
        next_state      = cur_state;
        err_next        = err_status;
        core_start_next = 1'b0;
        frame_done_next = 1'b0;

        case (cur_state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                if (timer == INIT_LAST) begin
                    next_state = ST_INPUT;
                end
            end
            ST_INPUT: begin
                if (in_beat_last) begin
                    if (in_error) begin
                        next_state              = ST_ERROR;
                        err_next[ERR_INPUT_LEN] = 1'b1;
                    end else begin
                        next_state      = ST_DECODE;
                        core_start_next = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (core_done) begin
                    next_state = ST_OUTPUT;
                end else if (timer == DECODE_LAST) begin
                    next_state            = ST_ERROR;
                    err_next[ERR_TIMEOUT] = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (out_done) begin
                    next_state      = ST_IDLE;
                    frame_done_next = 1'b1;
                end
            end
            ST_ERROR: begin
                if (clear_error) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        if (start && (cur_state != ST_IDLE)) begin
            err_next[ERR_START_BUSY] = 1'b1;
        end
        if (clear_error) begin
            err_next = '0;
        end
    end

    assign state = STATE_WIDTH'(cur_state);
    assign busy  = (cur_state != ST_IDLE);

endmodule

// File: tb/tb_polar_decode_sequencer.sv
// Bench for polar_decode_sequencer: one default instance and one with a short
// decode timeout and a 2-bit frame counter, both driven from shared inputs.
module tb_polar_decode_sequencer;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic in_beat_last = 1'b0;
    logic in_error = 1'b0;
    logic core_done = 1'b0;
    logic out_done = 1'b0;
    logic clear_error = 1'b0;

    logic [9:0]  state_a, state_b;
    logic        core_start_a, core_start_b;
    logic        busy_a, busy_b;
    logic        frame_done_a, frame_done_b;
    logic [2:0]  err_a, err_b;
    logic [15:0] fc_a;
    logic [1:0]  fc_b;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];
    int model_fc_a = 0;
    int model_fc_b = 0;

    always #5 clk = ~clk;

    polar_decode_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .in_beat_last(in_beat_last),
        .in_error(in_error), .core_done(core_done), .out_done(out_done),
        .clear_error(clear_error), .state(state_a), .core_start(core_start_a),
        .busy(busy_a), .frame_done(frame_done_a), .err_status(err_a),
        .frame_count(fc_a)
    );

    polar_decode_sequencer #(
        .DECODE_TIMEOUT(100),
        .FRAME_CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .in_beat_last(in_beat_last),
        .in_error(in_error), .core_done(core_done), .out_done(out_done),
        .clear_error(clear_error), .state(state_b), .core_start(core_start_b),
        .busy(busy_b), .frame_done(frame_done_b), .err_status(err_b),
        .frame_count(fc_b)
    );

    function automatic int st(input bit b);
        return b ? int'(state_b) : int'(state_a);
    endfunction

    function automatic int fc(input bit b);
        return b ? int'(fc_b) : int'(fc_a);
    endfunction

    function automatic logic fd(input bit b);
        return b ? frame_done_b : frame_done_a;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        {start, in_beat_last, in_error, core_done, out_done, clear_error} = '0;
        tick;
        tick;
        reset_n = 1'b1;
        model_fc_a = 0;
        model_fc_b = 0;
        exp_q.delete();
    endtask

    task automatic go_input(input bit b);
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 200 && st(b) != 2; i++) tick;
        tests_run++;
        if (st(b) !== 2) begin
            tests_failed++;
            $display("[TB] FAIL reach_input: state=%0d required 2", st(b));
        end
    endtask

    // Leaves the bench on the first DECODE cycle.
    task automatic go_decode(input bit b);
        go_input(b);
        in_beat_last = 1'b1;
        tick;
        in_beat_last = 1'b0;
    endtask

    // Drives out_done and records the frame count the model expects at frame_done.
    task automatic finish_frame(input bit b);
        if (b) begin
            model_fc_b = (model_fc_b + 1) % 4;
            exp_q.push_back(model_fc_b);
        end else begin
            model_fc_a = (model_fc_a + 1) % 65536;
            exp_q.push_back(model_fc_a);
        end
        out_done = 1'b1;
        tick;
        out_done = 1'b0;
    endtask

    task automatic check_frame_done(input bit b, input string name);
        int exp_v;
        tests_run++;
        if (fd(b) !== 1'b1 || exp_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s frame_done: got %0b required 1 (queue %0d)", name, fd(b), exp_q.size());
        end else begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if (fc(b) !== exp_v) begin
                tests_failed++;
                $display("[TB] FAIL %s frame_count: got %0d required %0d", name, fc(b), exp_v);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        tests_run++;
        if ({state_a, core_start_a, busy_a, frame_done_a, err_a, fc_a} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: state=%0d cs=%0b busy=%0b fd=%0b err=%0b fc=%0d required all 0",
                     state_a, core_start_a, busy_a, frame_done_a, err_a, fc_a);
        end
        do_reset;
    endtask

    task automatic test_nominal;
        int cnt;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        cnt = 0;
        while (state_a == 10'd1 && cnt < 100) begin
            cnt++;
            tick;
        end
        tests_run++;
        if (cnt !== 20) begin
            tests_failed++;
            $display("[TB] FAIL init_cycles: got %0d required 20", cnt);
        end
        tests_run++;
        if (state_a !== 10'd2) begin
            tests_failed++;
            $display("[TB] FAIL init_to_input: state=%0d required 2", state_a);
        end
        in_beat_last = 1'b1;
        tick;
        in_beat_last = 1'b0;
        tests_run++;
        if (state_a !== 10'd3 || core_start_a !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL core_start_first: state=%0d cs=%0b required 3/1", state_a, core_start_a);
        end
        tick;
        tests_run++;
        if (core_start_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL core_start_single: got %0b required 0", core_start_a);
        end
        repeat (498) tick;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        tests_run++;
        if (state_a !== 10'd4 || err_a !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL decode_to_output: state=%0d err=%b required 4/000", state_a, err_a);
        end
        finish_frame(1'b0);
        tests_run++;
        if (state_a !== 10'd0 || busy_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL output_to_idle: state=%0d busy=%0b required 0/0", state_a, busy_a);
        end
        check_frame_done(1'b0, "nominal");
        tick;
        tests_run++;
        if (frame_done_a !== 1'b0 || fc_a !== 16'd1) begin
            tests_failed++;
            $display("[TB] FAIL frame_done_single: fd=%0b fc=%0d required 0/1", frame_done_a, fc_a);
        end
    endtask

    task automatic test_input_error;
        do_reset;
        go_input(1'b0);
        in_beat_last = 1'b1;
        in_error = 1'b1;
        tick;
        in_beat_last = 1'b0;
        in_error = 1'b0;
        tests_run++;
        if (state_a !== 10'd5 || err_a !== 3'b001 || core_start_a !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL input_error: state=%0d err=%b cs=%0b required 5/001/0", state_a, err_a, core_start_a);
        end
        start = 1'b1;
        clear_error = 1'b1;
        tick;
        start = 1'b0;
        clear_error = 1'b0;
        tests_run++;
        if (state_a !== 10'd0 || err_a !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL clear_error: state=%0d err=%b required 0/000", state_a, err_a);
        end
        tick;
        tests_run++;
        if (state_a !== 10'd0) begin
            tests_failed++;
            $display("[TB] FAIL start_with_clear: state=%0d required 0", state_a);
        end
    endtask

    task automatic test_timeout;
        int cnt;
        do_reset;
        go_decode(1'b1);
        cnt = 0;
        while (state_b == 10'd3 && cnt < 300) begin
            cnt++;
            tick;
        end
        tests_run++;
        if (cnt !== 100) begin
            tests_failed++;
            $display("[TB] FAIL timeout_cycles: got %0d required 100", cnt);
        end
        repeat (3) tick;
        tests_run++;
        if (state_b !== 10'd5 || err_b !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL timeout_error: state=%0d err=%b required 5/010", state_b, err_b);
        end
        clear_error = 1'b1;
        tick;
        clear_error = 1'b0;
    endtask

    task automatic test_same_cycle;
        do_reset;
        go_decode(1'b1);
        repeat (99) tick;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        tests_run++;
        if (state_b !== 10'd4 || err_b !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL done_beats_timeout: state=%0d err=%b required 4/000", state_b, err_b);
        end
    endtask

    task automatic test_start_busy;
        do_reset;
        go_decode(1'b1);
        start = 1'b1;
        tick;
        start = 1'b0;
        tests_run++;
        if (state_b !== 10'd3 || err_b !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL start_busy: state=%0d err=%b required 3/100", state_b, err_b);
        end
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        tests_run++;
        if (state_b !== 10'd4 || err_b !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL err_sticky: state=%0d err=%b required 4/100", state_b, err_b);
        end
    endtask

    task automatic test_wrap_and_reset;
        do_reset;
        for (int f = 0; f < 5; f++) begin
            go_decode(1'b1);
            core_done = 1'b1;
            tick;
            core_done = 1'b0;
            finish_frame(1'b1);
            check_frame_done(1'b1, "wrap");
            if (f == 3) begin
                tests_run++;
                if (fc_b !== 2'd0) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_to_zero: got %0d required 0", fc_b);
                end
            end
        end
        out_done = 1'b1;
        tick;
        out_done = 1'b0;
        tests_run++;
        if (frame_done_b !== 1'b0 || fc_b !== 2'd1) begin
            tests_failed++;
            $display("[TB] FAIL out_done_idle_ignored: fd=%0b fc=%0d required 0/1", frame_done_b, fc_b);
        end
        go_input(1'b1);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({state_b, core_start_b, busy_b, frame_done_b, err_b, fc_b} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: state=%0d cs=%0b busy=%0b fd=%0b err=%b fc=%0d required all 0",
                     state_b, core_start_b, busy_b, frame_done_b, err_b, fc_b);
        end
        tick;
        reset_n = 1'b1;
        tick;
        tests_run++;
        if (state_b !== 10'd0 || frame_done_b !== 1'b0 || core_start_b !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_quiet: state=%0d fd=%0b cs=%0b required 0/0/0", state_b, frame_done_b, core_start_b);
        end
    endtask

    initial begin
        test_reset;
        test_nominal;
        test_input_error;
        test_timeout;
        test_same_cycle;
        test_start_busy;
        test_wrap_and_reset;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/polar_decode_sequencer.md
POLAR_DECODE_SEQUENCER -- requirements
Module: polar_decode_sequencer

Interface
REQ-001 The block SHALL have parameter STATE_WIDTH, default 10, meaning the width of the state bus broadcast to datapath controllers.
REQ-002 The block SHALL have parameter INIT_WAIT, default 20, meaning the number of BRAM-init wait cycles before input starts.
REQ-003 The block SHALL have parameter DECODE_TIMEOUT, default 16'd65535, meaning the maximum number of cycles allowed in DECODE.
REQ-004 The block SHALL have parameter TIMER_WIDTH, default 16, meaning the width of the shared cycle timer.
REQ-005 The block SHALL have parameter FRAME_CNT_WIDTH, default 16, meaning the width of the frame counter.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: request to decode one frame.
REQ-009 The block SHALL have port in_beat_last, input, 1 bit: an input AXIS beat with tlast was accepted this cycle (tvalid&tready&tlast).
REQ-010 The block SHALL have port in_error, input, 1 bit: length error flag from the input controller.
REQ-011 The block SHALL have port core_done, input, 1 bit: decoder core finished, single-cycle pulse.
REQ-012 The block SHALL have port out_done, input, 1 bit: output controller has sent the last beat of the frame.
REQ-013 The block SHALL have port clear_error, input, 1 bit: clears the error status and leaves ERROR.
REQ-014 The block SHALL have port state, output, STATE_WIDTH bits: current state code.
REQ-015 The block SHALL have port core_start, output, 1 bit: single-cycle decoder start pulse.
REQ-016 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-017 The block SHALL have port frame_done, output, 1 bit: single-cycle pulse when a frame completes.
REQ-018 The block SHALL have port err_status, output, 3 bits: sticky flags; bit0 input length error, bit1 decode timeout, bit2 start while busy.
REQ-019 The block SHALL have port frame_count, output, FRAME_CNT_WIDTH bits: number of completed frames.

Function
REQ-020 The state codes SHALL be IDLE=0, INIT=1, INPUT=2, DECODE=3, OUTPUT=4 and ERROR=5, zero-extended to STATE_WIDTH bits.
REQ-021 In IDLE, start SHALL move the block to INIT and clear the timer.
REQ-022 INIT SHALL count timer 0..INIT_WAIT-1 and move to INPUT on the cycle after timer==INIT_WAIT-1, giving exactly INIT_WAIT cycles in INIT.
REQ-023 In INPUT, in_beat_last with in_error low SHALL move the block to DECODE and clear the timer.
REQ-024 In INPUT, in_beat_last with in_error high SHALL move the block to ERROR and set err_status[0].
REQ-025 core_start SHALL be high for exactly the first cycle of DECODE (registered, 1-cycle latency from the INPUT exit condition).
REQ-026 In DECODE, core_done SHALL move the block to OUTPUT.
REQ-027 In DECODE, timer==DECODE_TIMEOUT-1 with core_done low SHALL move the block to ERROR and set err_status[1].
REQ-028 core_done SHALL win over a timeout occurring in the same cycle.
REQ-029 In OUTPUT, out_done SHALL move the block to IDLE, pulse frame_done for 1 cycle (the first IDLE cycle), and increment frame_count modulo 2^FRAME_CNT_WIDTH (all-ones wraps to 0).
REQ-030 ERROR SHALL be held until clear_error, which SHALL move the block to IDLE and zero err_status.
REQ-031 A start asserted in ERROR in the same cycle as clear_error SHALL be ignored.
REQ-032 start asserted in any state other than IDLE SHALL be ignored and SHALL set err_status[2].
REQ-033 core_done, in_beat_last and out_done outside their own states SHALL be ignored.
REQ-034 err_status bits SHALL be sticky and cleared only by clear_error or by reset.
REQ-035 All outputs SHALL be registered, except busy, which is decoded from state.

Reset
REQ-036 On reset_n low, the block SHALL immediately set state=IDLE, timer=0, core_start=0, frame_done=0, err_status=0, frame_count=0, busy=0.
REQ-037 Reset mid-frame SHALL abort without any pulse.
REQ-038 After deassertion, the first legal start SHALL be sampled on the first rising clk edge.

Structure
REQ-039 State codes, STATE_WIDTH and error bit indices SHALL live in a shared package, polar_pkg, used by the input, core and output controllers.
REQ-040 The timer SHALL be a single shared counter, cleared on every state change.
REQ-041 The block SHALL have no sub-module; an optional sub-module, seq_timer, MAY be used.

Verification
REQ-042 The bench SHALL check nominal flow: start pulse -> 20 cycles of INIT, INPUT, in_beat_last -> core_start high for 1 cycle, core_done after 500 cycles -> OUTPUT, out_done -> frame_done pulse and frame_count=1.
REQ-043 The bench SHALL check input error: in_beat_last with in_error=1 -> state=5 and err_status=3'b001; clear_error -> IDLE and err_status=0.
REQ-044 The bench SHALL check timeout with DECODE_TIMEOUT=100: no core_done -> ERROR after exactly 100 DECODE cycles and err_status[1]=1.
REQ-045 The bench SHALL check the same-cycle case: core_done on cycle 99 of DECODE (timeout=100) -> OUTPUT, with no error.
REQ-046 The bench SHALL check start while busy: start in DECODE -> state unchanged and err_status[2]=1.
REQ-047 The bench SHALL check wrap and reset: FRAME_CNT_WIDTH=2, run 4 frames -> frame_count=0; reset_n low mid-INPUT -> IDLE at once, with all outputs 0.
